// File: rtl/conv_window_gen_pkg.sv
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared types and helpers for the KxK convolution window
//             generator: default window size, window index type, pixel type
//             and the row/column to flat window index mapping.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

  localparam int K_DEFAULT  = 3;
  localparam int DW_DEFAULT = 9;

  // Flat index into a KxK window (0 .. K*K-1).
  typedef logic [$clog2(K_DEFAULT*K_DEFAULT)-1:0] win_idx_t;

  // One signed padded pixel as produced by the upstream streamer.
  typedef logic signed [DW_DEFAULT-1:0] pix_t;

  // Window layout is row-major: r=0 is the oldest row, c=0 the leftmost column.
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_window_gen_if.sv
// ============================================================================
//  Module   : conv_window_gen_if
//  Purpose  : Stream bundle of the window generator.
//    in_valid/in_ready/in_data     : upstream padded raster beat
//    out_valid/out_ready/out_win   : downstream KxK window per bank
//    frame_done                    : pulse after the last window of a frame
//  Modports : slave  - the window generator
//             master - the environment (streamer + MAC array side)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_window_gen_if #(
  parameter int N_BANKS = 8,
  parameter int DW      = 9,
  parameter int K       = 3
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data [0:N_BANKS-1];
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_win [0:N_BANKS-1][0:K*K-1];
  logic                 frame_done;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_win, frame_done
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_win, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/conv_line_buffer.sv
// ============================================================================
//  Module   : conv_line_buffer
//  Purpose  : One row of one bank: EXT_W x DW storage with asynchronous read
//             and synchronous write at the same address. Contents are not
//             reset; the window logic never consumes rows it has not filled.
//  Ports    : clk     - clock
//             we_i    - write enable
//             addr_i  - column address (read and write)
//             wdata_i - value written at addr_i on the next edge
//             rdata_o - current value at addr_i
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int EXT_W = 16,
  parameter int DW    = 9
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [$clog2(EXT_W)-1:0]     addr_i,
  input  logic signed [DW-1:0]         wdata_i,
  output logic signed [DW-1:0]         rdata_o
);

  logic signed [DW-1:0] mem_q [EXT_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read returns the pre-write value, which is what the row chain shifts on.
  assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/conv_window_gen.sv
// ============================================================================
//  Module   : conv_window_gen
//  Purpose  : Turns a zero-padded EXT_W x EXT_W raster (N_BANKS channels per
//             beat) into every fully populated KxK stride-1 window.
//             K-1 line buffers per bank feed a KxK shift-register window;
//             the window register drives out_win directly.
//  Ports    : clk  - clock
//             rst  - synchronous active-high reset
//             bus  - conv_window_gen_if.slave
//                    (in_valid/in_ready/in_data, out_valid/out_ready/out_win,
//                     frame_done)
//  Note     : the interface instance must use the same N_BANKS, DW and K.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_gen
  import conv_pkg::*;
#(
  parameter int N_BANKS = 8,
  parameter int DW      = 9,
  parameter int EXT_W   = 16,
  parameter int K       = K_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  conv_window_gen_if.slave  bus
);

  localparam int             XW        = $clog2(EXT_W);
  localparam logic [XW-1:0]  POS_LAST  = XW'(EXT_W - 1);
  localparam logic [XW-1:0]  WIN_START = XW'(K - 1);

  logic [XW-1:0] x_q, x_d;
  logic [XW-1:0] y_q, y_d;
  logic          out_valid_q, out_valid_d;
  logic          last_pending_q, last_pending_d;
  logic          frame_done_q, frame_done_d;

  logic signed [DW-1:0] win_q [N_BANKS][K*K];
  logic signed [DW-1:0] win_d [N_BANKS][K*K];

  // lb_rd[b][j] holds row y-1-j at column x for bank b.
  logic signed [DW-1:0] lb_rd [N_BANKS][K-1];

  logic in_ready;
  logic in_fire;
  logic out_fire;
  logic win_complete;
  logic last_beat;

  // No skid buffer: a new beat is only taken when the held window leaves.
  assign in_ready     = !out_valid_q || bus.out_ready;
  assign in_fire      = bus.in_valid && in_ready;
  assign out_fire     = out_valid_q && bus.out_ready;
  assign win_complete = (x_q >= WIN_START) && (y_q >= WIN_START);
  assign last_beat    = (x_q == POS_LAST) && (y_q == POS_LAST);

  // --------------------------------------------------------------------------
  // Line buffers: row j is written with what row j-1 held at this column, so
  // one write pulse ages the whole column by a row.
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    for (genvar j = 0; j < K-1; j++) begin : g_row
      logic signed [DW-1:0] wdata;

      if (j == 0) begin : g_first
        assign wdata = bus.in_data[b];
      end else begin : g_chain
        assign wdata = lb_rd[b][j-1];
      end

      conv_line_buffer #(
        .EXT_W (EXT_W),
        .DW    (DW)
      ) u_lb (
        .clk     (clk),
        .we_i    (in_fire),
        .addr_i  (x_q),
        .wdata_i (wdata),
        .rdata_o (lb_rd[b][j])
      );
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    x_d            = x_q;
    y_d            = y_q;
    out_valid_d    = out_valid_q;
    last_pending_d = last_pending_q;
    frame_done_d   = out_fire && last_pending_q;
    win_d          = win_q;

    if (in_fire) begin
      if (x_q == POS_LAST) begin
        x_d = '0;
        y_d = (y_q == POS_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end

      // Shift columns left, then load the new rightmost column: oldest row
      // from the deepest line buffer down to the incoming beat at r=K-1.
      for (int b = 0; b < N_BANKS; b++) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K-1; c++) begin
            win_d[b][win_idx(r, c, K)] = win_q[b][win_idx(r, c+1, K)];
          end
        end
        for (int r = 0; r < K-1; r++) begin
          win_d[b][win_idx(r, K-1, K)] = lb_rd[b][K-2-r];
        end
        win_d[b][win_idx(K-1, K-1, K)] = bus.in_data[b];
      end
    end

    // A completing beat wins over retiring the old window; this keeps
    // out_valid high across back-to-back windows in the same row.
    if (in_fire && win_complete) begin
      out_valid_d    = 1'b1;
      last_pending_d = last_beat;
    end else if (out_fire) begin
      out_valid_d    = 1'b0;
      last_pending_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q            <= '0;
      y_q            <= '0;
      out_valid_q    <= 1'b0;
      last_pending_q <= 1'b0;
      frame_done_q   <= 1'b0;
      win_q          <= '{default: '0};
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      out_valid_q    <= out_valid_d;
      last_pending_q <= last_pending_d;
      frame_done_q   <= frame_done_d;
      win_q          <= win_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_win    = win_q;
  assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_gen.sv
// ============================================================================
//  Module   : tb_conv_window_gen
//  Purpose  : Self-checking bench for conv_window_gen. Frames are held in an
//             image array; every accepted window is compared with the KxK
//             patch cut directly from that image.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_window_gen;

  localparam int N_BANKS = 8;
  localparam int DW      = 9;
  localparam int EXT_W   = 16;
  localparam int K       = 3;
  localparam int NW1     = EXT_W - K + 1;
  localparam int NWIN    = NW1 * NW1;
  localparam int FRAME   = EXT_W * EXT_W;

  logic clk;
  logic rst;

  conv_window_gen_if #(.N_BANKS(N_BANKS), .DW(DW), .K(K)) bus ();

  conv_window_gen #(
    .N_BANKS (N_BANKS),
    .DW      (DW),
    .EXT_W   (EXT_W),
    .K       (K)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source image: img[bank][y][x]
  logic signed [DW-1:0] img [N_BANKS][EXT_W][EXT_W];

  int n_checks = 0;
  int n_pass   = 0;

  int exp_first [K*K] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
  int exp_row   [K*K] = '{16, 17, 18, 32, 33, 34, 48, 49, 50};
  int exp_last  [K*K] = '{221, 222, 223, 237, 238, 239, 253, 254, 255};

  // Driver status
  bit drv_done;
  bit drv_timeout;

  // Monitor state
  int clr_req = 0;
  int clr_seen = 0;
  int win_cnt, win_bad, first_bad, fd_cnt, fd_bad, row_bad, first_valid_beats;
  int widx, beats_acc, last_in_x;
  bit last_fire_prev, last_in_fire;
  int cap [4][K*K];

  // Expected element e of window number w (row-major window order).
  function automatic int exp_elem(input int w, input int b, input int e);
    int wy, wx;
    wy = w / NW1;
    wx = w % NW1;
    return int'(img[b][wy + e / K][wx + e % K]);
  endfunction

  always @(negedge clk) begin : monitor
    int nbad;
    int slot;
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      win_cnt = 0; win_bad = 0; first_bad = -1; fd_cnt = 0; fd_bad = 0;
      row_bad = 0; first_valid_beats = -1;
      for (int s = 0; s < 4; s++)
        for (int e = 0; e < K*K; e++) cap[s][e] = -9999;
    end
    if (rst) begin
      widx = 0; beats_acc = 0; last_fire_prev = 0; last_in_fire = 0; last_in_x = 0;
    end else begin
      if (bus.frame_done) begin
        fd_cnt++;
        if (!last_fire_prev) fd_bad++;
      end
      last_fire_prev = 0;
      if (bus.out_valid && first_valid_beats < 0) first_valid_beats = beats_acc;
      if (last_in_fire && last_in_x < K-1 && bus.out_valid) row_bad++;
      if (bus.out_valid && bus.out_ready) begin
        nbad = 0;
        for (int b = 0; b < N_BANKS; b++)
          for (int e = 0; e < K*K; e++)
            if (int'(bus.out_win[b][e]) != exp_elem(widx, b, e)) nbad++;
        if (nbad != 0) begin
          win_bad++;
          if (first_bad < 0) first_bad = win_cnt;
        end
        slot = (win_cnt == 0) ? 0 : (win_cnt == 14) ? 1 :
               (win_cnt == NWIN-1) ? 2 : (win_cnt == NWIN) ? 3 : -1;
        if (slot >= 0)
          for (int e = 0; e < K*K; e++) cap[slot][e] = int'(bus.out_win[0][e]);
        last_fire_prev = (widx == NWIN-1);
        widx = (widx + 1) % NWIN;
        win_cnt++;
      end
      last_in_fire = bus.in_valid && bus.in_ready;
      last_in_x    = beats_acc % EXT_W;
      if (last_in_fire) beats_acc++;
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic fill_ramp();
    for (int b = 0; b < N_BANKS; b++)
      for (int y = 0; y < EXT_W; y++)
        for (int x = 0; x < EXT_W; x++)
          img[b][y][x] = DW'(y * EXT_W + x + b);
  endtask

  task automatic fill_random();
    for (int b = 0; b < N_BANKS; b++)
      for (int y = 0; y < EXT_W; y++)
        for (int x = 0; x < EXT_W; x++)
          img[b][y][x] = DW'($urandom_range(0, (1 << DW) - 1));
  endtask

  task automatic start_test();
    clr_req++;
    @(posedge clk); #1;
  endtask

  task automatic drive_beats(input int n_beats, input int bubble_pct);
    int x, y, waitc;
    bit ok;
    x = 0; y = 0; drv_done = 0; drv_timeout = 0;
    for (int i = 0; i < n_beats && !drv_timeout; i++) begin
      while (bubble_pct > 0 && $urandom_range(0, 99) < bubble_pct) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      for (int b = 0; b < N_BANKS; b++) bus.in_data[b] = img[b][y][x];
      waitc = 0; ok = 0;
      while (!ok && waitc < 200) begin
        @(negedge clk);
        ok = bus.in_ready;
        @(posedge clk); #1;
        waitc++;
      end
      if (!ok) drv_timeout = 1;
      else if (x == EXT_W-1) begin
        x = 0;
        y = (y == EXT_W-1) ? 0 : y + 1;
      end else begin
        x++;
      end
    end
    bus.in_valid = 1'b0;
    drv_done = 1;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    int nz;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    nz = 0;
    for (int b = 0; b < N_BANKS; b++)
      for (int e = 0; e < K*K; e++)
        if (bus.out_win[b][e] !== '0) nz++;
    n_checks++; if (nz !== 0) $display("FAIL reset_window_zero: %0d nonzero elements, want 0", nz); else n_pass++;
  endtask

  task automatic test_ramp_frame();
    fill_ramp();
    start_test();
    drive_beats(FRAME, 0);
    drain();
    n_checks++; if (drv_timeout) $display("FAIL ramp_timeout: input stalled, want accepted"); else n_pass++;
    n_checks++; if (first_valid_beats !== (K-1)*EXT_W + K) $display("FAIL ramp_first_latency: first out_valid after %0d beats, want %0d", first_valid_beats, (K-1)*EXT_W + K); else n_pass++;
    n_checks++; if (win_cnt !== NWIN) $display("FAIL ramp_count: got %0d want %0d", win_cnt, NWIN); else n_pass++;
    n_checks++; if (win_bad !== 0) $display("FAIL ramp_content: %0d bad windows (first %0d), want 0", win_bad, first_bad); else n_pass++;
    n_checks++; if (fd_cnt !== 1 || fd_bad !== 0) $display("FAIL ramp_frame_done: %0d pulses (%0d misplaced), want 1 (0)", fd_cnt, fd_bad); else n_pass++;
    for (int e = 0; e < K*K; e++) begin
      n_checks++; if (cap[0][e] !== exp_first[e]) $display("FAIL ramp_first_win[%0d]: got %0d want %0d", e, cap[0][e], exp_first[e]); else n_pass++;
      n_checks++; if (cap[2][e] !== exp_last[e]) $display("FAIL ramp_last_win[%0d]: got %0d want %0d", e, cap[2][e], exp_last[e]); else n_pass++;
    end
  endtask

  task automatic test_row_boundary();
    fill_ramp();
    start_test();
    drive_beats(FRAME, 30);
    drain();
    n_checks++; if (row_bad !== 0) $display("FAIL row_no_valid_x01: %0d windows after x<2 beats, want 0", row_bad); else n_pass++;
    n_checks++; if (win_cnt !== NWIN || win_bad !== 0) $display("FAIL row_sequence: %0d windows, %0d bad, want %0d, 0", win_cnt, win_bad, NWIN); else n_pass++;
    for (int e = 0; e < K*K; e++) begin
      n_checks++; if (cap[1][e] !== exp_row[e]) $display("FAIL row_win_x2y3[%0d]: got %0d want %0d", e, cap[1][e], exp_row[e]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int si, nbad, guard;
    bit stalled;
    fill_random();
    start_test();
    fork
      drive_beats(FRAME, 0);
      begin
        guard = 0; stalled = 0;
        while (!stalled && guard < 2000) begin
          if (win_cnt >= 50 && bus.out_valid) begin
            bus.out_ready = 1'b0;
            stalled = 1;
          end else begin
            @(posedge clk); #1;
            guard++;
          end
        end
        n_checks++; if (!stalled) $display("FAIL bp_reach_window: no interior window within budget"); else n_pass++;
        if (stalled) begin
          si = widx;
          for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            nbad = 0;
            for (int b = 0; b < N_BANKS; b++)
              for (int e = 0; e < K*K; e++)
                if (int'(bus.out_win[b][e]) != exp_elem(si, b, e)) nbad++;
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid cyc %0d: got %b want 1", cyc, bus.out_valid); else n_pass++;
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d: got %b want 0", cyc, bus.in_ready); else n_pass++;
            n_checks++; if (nbad !== 0) $display("FAIL bp_win_hold cyc %0d: %0d elements differ from window %0d, want 0", cyc, nbad, si); else n_pass++;
            @(posedge clk); #1;
          end
          bus.out_ready = 1'b1;
        end
      end
    join
    drain();
    n_checks++; if (drv_timeout) $display("FAIL bp_timeout: input stalled, want accepted"); else n_pass++;
    n_checks++; if (win_cnt !== NWIN || win_bad !== 0) $display("FAIL bp_sequence: %0d windows, %0d bad (first %0d), want %0d, 0", win_cnt, win_bad, first_bad, NWIN); else n_pass++;
    n_checks++; if (fd_cnt !== 1 || fd_bad !== 0) $display("FAIL bp_frame_done: %0d pulses (%0d misplaced), want 1 (0)", fd_cnt, fd_bad); else n_pass++;
  endtask

  task automatic test_bubbles();
    fill_random();
    start_test();
    fork
      drive_beats(FRAME, 50);
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    n_checks++; if (drv_timeout) $display("FAIL bub_timeout: input stalled, want accepted"); else n_pass++;
    n_checks++; if (win_cnt !== NWIN) $display("FAIL bub_count: got %0d want %0d", win_cnt, NWIN); else n_pass++;
    n_checks++; if (win_bad !== 0) $display("FAIL bub_content: %0d bad windows (first %0d), want 0", win_bad, first_bad); else n_pass++;
    n_checks++; if (row_bad !== 0) $display("FAIL bub_row_valid: %0d windows after x<2 beats, want 0", row_bad); else n_pass++;
    n_checks++; if (fd_cnt !== 1 || fd_bad !== 0) $display("FAIL bub_frame_done: %0d pulses (%0d misplaced), want 1 (0)", fd_cnt, fd_bad); else n_pass++;
  endtask

  task automatic test_back_to_back();
    fill_ramp();
    start_test();
    drive_beats(2 * FRAME, 0);
    drain();
    n_checks++; if (win_cnt !== 2 * NWIN) $display("FAIL b2b_count: got %0d want %0d", win_cnt, 2 * NWIN); else n_pass++;
    n_checks++; if (win_bad !== 0) $display("FAIL b2b_content: %0d bad windows (first %0d), want 0", win_bad, first_bad); else n_pass++;
    n_checks++; if (fd_cnt !== 2 || fd_bad !== 0) $display("FAIL b2b_frame_done: %0d pulses (%0d misplaced), want 2 (0)", fd_cnt, fd_bad); else n_pass++;
    for (int e = 0; e < K*K; e++) begin
      n_checks++; if (cap[3][e] !== exp_first[e]) $display("FAIL b2b_second_first_win[%0d]: got %0d want %0d", e, cap[3][e], exp_first[e]); else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    fill_ramp();
    start_test();
    drive_beats(100, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.frame_done !== 1'b0) $display("FAIL midrst_frame_done: got %b want 0", bus.frame_done); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    start_test();
    drive_beats(FRAME, 0);
    drain();
    n_checks++; if (win_cnt !== NWIN || win_bad !== 0) $display("FAIL midrst_sequence: %0d windows, %0d bad (first %0d), want %0d, 0", win_cnt, win_bad, first_bad, NWIN); else n_pass++;
    n_checks++; if (fd_cnt !== 1) $display("FAIL midrst_frame_done: %0d pulses, want 1", fd_cnt); else n_pass++;
    for (int e = 0; e < K*K; e++) begin
      n_checks++; if (cap[0][e] !== exp_first[e]) $display("FAIL midrst_first_win[%0d]: got %0d want %0d", e, cap[0][e], exp_first[e]); else n_pass++;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int b = 0; b < N_BANKS; b++) bus.in_data[b] = '0;
    test_reset();
    test_ramp_frame();
    test_row_boundary();
    test_backpressure();
    test_bubbles();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Consumes the zero-padded raster stream produced by the padded BRAM streamer, EXT_W x EXT_W positions with N_BANKS signed channels per beat.
- Emits every fully populated KxK sliding window (stride 1) to the downstream convolution MAC array.
- Uses K-1 line buffers per bank plus a KxK register window.
- Valid/ready handshake on both sides; nothing is dropped under backpressure.

Parameters:
- N_BANKS, 8, channels per beat (one per bank).
- DW, 9, signed element width; equals the upstream streamer's OUT_DW.
- EXT_W, 16, padded frame width and height (IMG_W + 2*PAD). Must satisfy EXT_W >= K.
- K, 3, window size. Must satisfy K >= 2.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  N_BANKS x DW signed  one padded pixel per bank (unpacked [0:N_BANKS-1]).
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts the window.
- out_win  out  N_BANKS x K*K x DW signed  window, [bank][r*K+c]. r=0 is the oldest row; c=0 is the leftmost column.
- frame_done  out  1  one-cycle pulse when the last window of a frame is accepted.

Behaviour:
- Handshake definitions:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). No skid buffer.
- Position counters x, y, each $clog2(EXT_W) bits, index the beat being accepted.
  - Advance only on in_fire; x wraps at EXT_W-1 and then increments y.
  - y wraps at EXT_W-1 back to 0. The next frame starts with no other action.
- Line buffers, per bank, K-1 rows of EXT_W entries (lb[0] = row y-1 ... lb[K-2] = row y-K+1):
  - Combinational read at column x.
  - On in_fire: lb[j][x] <= lb[j-1][x] for j descending, then lb[0][x] <= in_data.
  - Contents are not reset. Stale data is never used, because windows require y >= K-1.
- Window register, per bank:
  - On in_fire: columns shift left (c <= c+1).
  - New column c=K-1 = {lb[K-2][x], ..., lb[0][x], in_data} for rows 0..K-1.
  - out_win is driven directly from this register.
- Window emission:
  - On in_fire with x >= K-1 and y >= K-1: out_valid <= 1 next cycle (1-cycle latency from the completing beat).
  - Else if out_fire: out_valid <= 0.
  - Else out_valid holds.
- Stall: with out_valid=1 and out_ready=0, in_ready=0. Window, counters and line buffers hold, so out_win is stable.
- Simultaneous out_fire and in_fire: the window shifts in the same edge. out_valid stays 1 only if the new beat completes a window.
- Windows never span rows. The beats at x < K-1 refill the window columns silently.
- Windows per frame = (EXT_W-K+1)^2.
- frame_done:
  - Registered one-cycle pulse, the cycle after out_fire of the window whose completing beat was (x=EXT_W-1, y=EXT_W-1).
  - Track this with a 1-bit last_pending flag set alongside out_valid.
- No arithmetic on data; element values pass through unchanged.
- Reset, including mid-frame, on the edge after rst is sampled high:
  - x=0, y=0, out_valid=0, frame_done=0, last_pending=0.
  - Window register = 0; in_ready is then 1.
  - A partial frame is discarded. Upstream must restart its frame after reset.

Decomposition:
- Package conv_pkg holds:
  - localparam K_DEFAULT=3.
  - typedef win_idx_t (index 0..K*K-1).
  - function win_idx(r,c) = r*K+c.
  - typedef logic signed [DW-1:0] pix_t (parameterised via the package default DW=9).
- One sub-module, conv_line_buffer: a single-bank, single-row EXT_W x DW memory.
  - Combinational read, synchronous write at the same address.
  - Instantiated N_BANKS*(K-1) times.

Test Plan:
- Ramp frame, out_ready=1, bank b data = (y*16+x) + b:
  - First out_valid occurs the cycle after beat 34 (x=2,y=2).
  - Bank 0 window = {0,1,2,16,17,18,32,33,34}.
  - Exactly 196 windows per frame.
  - Last bank-0 window = {221,222,223,237,238,239,253,254,255}.
  - frame_done pulses once, one cycle after the last out_fire.
- Row boundary:
  - No out_valid after the beats at x=0 or x=1 of any row.
  - The window at (x=2,y=3) contains only columns 0..2 of rows 1..3 ({16,17,18,32,33,34,48,49,50} for bank 0).
- Backpressure: hold out_ready=0 for 5 cycles during an interior window.
  - out_win and out_valid remain constant and in_ready=0 throughout.
  - After release, the window sequence is identical to the no-stall run.
- Upstream bubbles: in_valid toggled randomly at 50%.
  - Window sequence and count (196) are unchanged; frame_done count is 1.
- Back-to-back frames: two ramp frames streamed with no gap.
  - The second frame's first window equals {0,1,2,16,17,18,32,33,34}; no cross-frame contamination.
  - 392 windows in total; frame_done pulses 2 times.
- Mid-frame reset: assert rst for 1 cycle at beat 100.
  - Next cycle: out_valid=0, frame_done=0, in_ready=1.
  - A fresh frame then yields first window {0,1,2,16,17,18,32,33,34} and 196 windows.
